// File: rtl/gate_pkg.sv
// Shared constants, gate bit positions and FSM encoding for the gate vector sequencer.
package gate_pkg;

  localparam int GATE_N = 7;
  localparam int N_VEC  = 4;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the basic gate bank, bit order matches gate_res_i.
module gate_ref_model
  import gate_pkg::*;
(
  input  logic              i_a,
  input  logic              i_b,
  output logic [GATE_N-1:0] o_exp
);

  // Expected response of every gate for the current a/b pair
  always_comb begin
    o_exp            = '0;
    o_exp[GATE_AND]  = i_a & i_b;
    o_exp[GATE_OR]   = i_a | i_b;
    o_exp[GATE_NOT]  = ~i_a;
    o_exp[GATE_NAND] = ~(i_a & i_b);
    o_exp[GATE_NOR]  = ~(i_a | i_b);
    o_exp[GATE_XOR]  = i_a ^ i_b;
    o_exp[GATE_XNOR] = ~(i_a ^ i_b);
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Steps the gate bank through all four a/b vectors, scores the sampled outputs.
// Optional first-failure capture is built when FAIL_CAPTURE_EN is defined.
module gate_vector_sequencer
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              a_o,
  output logic              b_o,
  input  logic [GATE_N-1:0] gate_res_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        err_cnt,
  output logic [GATE_N-1:0] fail_mask,
  output logic [1:0]        first_fail_vec,
  output logic              first_fail_vld
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       IDX_LAST = 2'(N_VEC - 1);

  state_t              r_state;
  logic [1:0]          r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_a;
  logic                r_b;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [2:0]          r_err_cnt;
  logic [GATE_N-1:0]   r_fail_mask;
  logic [GATE_N-1:0]   w_exp;
  logic [GATE_N-1:0]   w_mism;
  logic                w_start_acc;
  logic                w_check;

  gate_ref_model u_ref (
    .i_a   (r_a),
    .i_b   (r_b),
    .o_exp (w_exp)
  );

  assign w_mism      = gate_res_i ^ w_exp;
  assign w_start_acc = (r_state == ST_IDLE) & start;
  assign w_check     = (r_state == ST_CHECK);

  // Sequencer FSM with settle counter and run score registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= 3'd0;
      r_fail_mask <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_err_cnt   <= 3'd0;
            r_fail_mask <= '0;
            r_pass      <= 1'b0;
            r_idx       <= 2'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_cnt       <= CNT_LOAD;
            r_busy      <= 1'b1;
            r_state     <= ST_SETTLE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_CHECK: begin
          r_fail_mask <= r_fail_mask | w_mism;
          if (|w_mism) begin
            r_err_cnt <= r_err_cnt + 3'd1;
          end else begin
            r_err_cnt <= r_err_cnt;
          end
          if (r_idx == IDX_LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_idx      <= r_idx + 2'd1;
            {r_a, r_b} <= r_idx + 2'd1;
            r_cnt      <= CNT_LOAD;
            r_state    <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          // err_cnt already includes the last vector's result here
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_pass  <= (r_err_cnt == 3'd0);
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FAIL_CAPTURE_EN
  logic [1:0] r_ff_vec;
  logic       r_ff_vld;

  // Latch the index of the first failing vector of the run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_vec <= 2'd0;
      r_ff_vld <= 1'b0;
    end else if (w_start_acc) begin
      r_ff_vec <= 2'd0;
      r_ff_vld <= 1'b0;
    end else if (w_check && (|w_mism) && !r_ff_vld) begin
      r_ff_vec <= r_idx;
      r_ff_vld <= 1'b1;
    end else begin
      r_ff_vec <= r_ff_vec;
      r_ff_vld <= r_ff_vld;
    end
  end

  assign first_fail_vec = r_ff_vec;
  assign first_fail_vld = r_ff_vld;
`else
  logic w_unused;
  assign w_unused       = w_start_acc ^ w_check;
  assign first_fail_vec = 2'd0;
  assign first_fail_vld = 1'b0;
`endif

  assign a_o       = r_a;
  assign b_o       = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign fail_mask = r_fail_mask;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Table-driven bench: two sequencers (settle 2 and settle 1) driving a faultable gate bank model.
module tb_gate_vector_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] start_w;
  logic [1:0] a_w, b_w, busy_w, done_w, pass_w, fvld_w;
  logic [2:0] err_w  [2];
  logic [6:0] mask_w [2];
  logic [6:0] res_w  [2];
  logic [1:0] ffv_w  [2];
  int         fault;
  int         n_cmp;
  int         n_fail;

  typedef struct {
    int         d;
    int         f;
    int         rs;
    logic [2:0] err;
    logic [6:0] mask;
    logic       pass;
    logic [1:0] ffv;
  } vec_t;

  vec_t tbl [10];

  // Gate bank with selectable faults
  function automatic logic [6:0] bank(input logic a, input logic b, input int f);
    logic [6:0] g;
    g = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    case (f)
      1: g[4] = 1'b1;
      2: begin g[5] = ~(a ^ b); g[6] = a ^ b; end
      3: g = 7'h00;
      4: g[0] = 1'b1;
      5: g[2] = a;
      6: g[1] = 1'b0;
      default: ;
    endcase
    return g;
  endfunction

  assign res_w[0] = bank(a_w[0], b_w[0], fault);
  assign res_w[1] = bank(a_w[1], b_w[1], fault);

  gate_vector_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .a_o(a_w[0]), .b_o(b_w[0]),
    .gate_res_i(res_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_cnt(err_w[0]), .fail_mask(mask_w[0]), .first_fail_vec(ffv_w[0]),
    .first_fail_vld(fvld_w[0])
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .a_o(a_w[1]), .b_o(b_w[1]),
    .gate_res_i(res_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_cnt(err_w[1]), .fail_mask(mask_w[1]), .first_fail_vec(ffv_w[1]),
    .first_fail_vld(fvld_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d a/b", tag, d), {30'd0, a_w[d], b_w[d]}, 32'd0);
      chk($sformatf("%s d%0d busy/done/pass", tag, d), {29'd0, busy_w[d], done_w[d], pass_w[d]}, 32'd0);
      chk($sformatf("%s d%0d err_cnt", tag, d), {29'd0, err_w[d]}, 32'd0);
      chk($sformatf("%s d%0d fail_mask", tag, d), {25'd0, mask_w[d]}, 32'd0);
      chk($sformatf("%s d%0d first_fail", tag, d), {29'd0, ffv_w[d], fvld_w[d]}, 32'd0);
    end
  endtask

  // One full run on sequencer d; rs is the cycle at which a spurious start is pulsed (-1 none)
  task automatic run(input int d, input int f, input int rs, input logic [2:0] e_err,
                     input logic [6:0] e_mask, input logic e_pass, input logic [1:0] e_ffv);
    int per;
    int vec;
    logic [1:0] x_ffv;
    logic       x_fvld;
    per = (d == 0) ? 3 : 2;
    @(negedge clk);
    fault = f;
    start_w[d] = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 4 * per + 2; k++) begin
      @(negedge clk);
      start_w[d] = (k == rs);
      vec = (k < 4 * per) ? (k / per) : 3;
      chk($sformatf("d%0d f%0d c%0d a/b", d, f, k), {30'd0, a_w[d], b_w[d]}, 32'(vec));
      chk($sformatf("d%0d f%0d c%0d done", d, f, k), {31'd0, done_w[d]}, {31'd0, k == 4 * per + 1});
      chk($sformatf("d%0d f%0d c%0d busy", d, f, k), {31'd0, busy_w[d]}, {31'd0, k <= 4 * per});
      if (k <= 4 * per) begin
        chk($sformatf("d%0d f%0d c%0d pass_low", d, f, k), {31'd0, pass_w[d]}, 32'd0);
      end
    end
    start_w[d] = 1'b0;
`ifdef FAIL_CAPTURE_EN
    x_ffv  = e_ffv;
    x_fvld = (e_err != 3'd0);
`else
    x_ffv  = 2'd0;
    x_fvld = 1'b0;
`endif
    chk($sformatf("d%0d f%0d err_cnt", d, f), {29'd0, err_w[d]}, {29'd0, e_err});
    chk($sformatf("d%0d f%0d fail_mask", d, f), {25'd0, mask_w[d]}, {25'd0, e_mask});
    chk($sformatf("d%0d f%0d pass", d, f), {31'd0, pass_w[d]}, {31'd0, e_pass});
    chk($sformatf("d%0d f%0d first_fail_vec", d, f), {30'd0, ffv_w[d]}, {30'd0, x_ffv});
    chk($sformatf("d%0d f%0d first_fail_vld", d, f), {31'd0, fvld_w[d]}, {31'd0, x_fvld});
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    fault   = 0;
    start_w = 2'b00;
    rst_n   = 1'b0;

    tbl[0] = '{d:0, f:0, rs:-1, err:3'd0, mask:7'b0000000, pass:1'b1, ffv:2'd0};
    tbl[1] = '{d:0, f:1, rs:-1, err:3'd3, mask:7'b0010000, pass:1'b0, ffv:2'd1};
    tbl[2] = '{d:0, f:2, rs:-1, err:3'd4, mask:7'b1100000, pass:1'b0, ffv:2'd0};
    tbl[3] = '{d:0, f:3, rs:-1, err:3'd4, mask:7'b1111111, pass:1'b0, ffv:2'd0};
    tbl[4] = '{d:0, f:4, rs:-1, err:3'd3, mask:7'b0000001, pass:1'b0, ffv:2'd0};
    tbl[5] = '{d:0, f:5, rs:-1, err:3'd4, mask:7'b0000100, pass:1'b0, ffv:2'd0};
    tbl[6] = '{d:0, f:6, rs:5,  err:3'd3, mask:7'b0000010, pass:1'b0, ffv:2'd1};
    tbl[7] = '{d:0, f:0, rs:-1, err:3'd0, mask:7'b0000000, pass:1'b1, ffv:2'd0};
    tbl[8] = '{d:1, f:0, rs:-1, err:3'd0, mask:7'b0000000, pass:1'b1, ffv:2'd0};
    tbl[9] = '{d:1, f:2, rs:-1, err:3'd4, mask:7'b1100000, pass:1'b0, ffv:2'd0};

    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_zero("idle_hold");

    for (int i = 0; i < 10; i++) begin
      run(tbl[i].d, tbl[i].f, tbl[i].rs, tbl[i].err, tbl[i].mask, tbl[i].pass, tbl[i].ffv);
    end

    // Reset in the middle of a failing run: immediate clear, no done pulse
    @(negedge clk);
    fault = 1;
    start_w[0] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start_w[0] = 1'b0;
    end
    chk("mid_run busy before reset", {31'd0, busy_w[0]}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_zero("mid_run_reset");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("reset_hold c%0d done", k), {31'd0, done_w[0]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset pass", {31'd0, pass_w[0]}, 32'd0);
    run(0, 0, -1, 3'd0, 7'b0000000, 1'b1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
